// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 128x16 single-port data memory between fetch (read-only) and load/store
module mem_port_arbiter #(
   parameter int DEPTH        = 128,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ready,
   output logic        if_rsp_valid,
   output logic [15:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [15:0] ls_addr,
   input  logic [15:0] ls_wdata,
   output logic        ls_ready,
   output logic        ls_rsp_valid,
   output logic [15:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_read_rq,
   output logic        mem_write_rq,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]       state;
   logic             owner;      // 0 = fetch, 1 = load/store
   logic [15:0]      addr_q;
   logic [15:0]      wdata_q;
   logic             we_q;
   logic             err_q;
   logic [CNT_W-1:0] starve_cnt;
   logic [15:0]      if_rdata_q;
   logic [15:0]      ls_rdata_q;

   logic in_range;
   logic grant_if;
   logic in_access;

   assign in_range  = addr_q < 16'(DEPTH);
   assign in_access = (state == S_ACCESS);

   // Load/store has priority unless fetch has already lost STARVE_LIMIT times in a row.
   assign grant_if = if_req && (!ls_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         addr_q     <= 16'h0;
         wdata_q    <= 16'h0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         starve_cnt <= '0;
         if_rdata_q <= 16'h0;
         ls_rdata_q <= 16'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (if_req || ls_req) begin
                  owner   <= !grant_if;
                  addr_q  <= grant_if ? if_addr : ls_addr;
                  we_q    <= grant_if ? 1'b0 : ls_we;
                  wdata_q <= grant_if ? 16'h0 : ls_wdata;
                  state   <= S_ACCESS;
               end
               // A fetch request that is pending while load/store wins counts as a loss.
               if (if_req && !grant_if) begin
                  if (starve_cnt < CNT_W'(STARVE_LIMIT))
                     starve_cnt <= starve_cnt + CNT_W'(1);
               end else begin
                  starve_cnt <= '0;
               end
            end
            S_ACCESS: begin
               err_q <= !in_range;
               if (owner)
                  ls_rdata_q <= (in_range && !we_q) ? mem_rdata : 16'h0;
               else
                  if_rdata_q <= in_range ? mem_rdata : 16'h0;
               state <= S_RESP;
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign if_ready     = in_access && !owner;
   assign ls_ready     = in_access && owner;
   assign if_rsp_valid = (state == S_RESP) && !owner;
   assign ls_rsp_valid = (state == S_RESP) && owner;
   assign ls_err       = (state == S_RESP) && err_q;

   assign mem_read_rq  = in_access && in_range && !we_q;
   assign mem_write_rq = in_access && in_range && we_q;
   assign mem_addr     = (in_access && in_range) ? addr_q : 16'h0;
   assign mem_wdata    = mem_write_rq ? wdata_q : 16'h0;

   assign if_rdata = if_rdata_q;
   assign ls_rdata = ls_rdata_q;
   assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural memory and arbitration model
module tb_mem_port_arbiter;

   localparam int DEPTH        = 128;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ready;
   logic        if_rsp_valid;
   logic [15:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [15:0] ls_addr;
   logic [15:0] ls_wdata;
   logic        ls_ready;
   logic        ls_rsp_valid;
   logic [15:0] ls_rdata;
   logic        ls_err;
   logic        mem_read_rq;
   logic        mem_write_rq;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem     [0:DEPTH-1];
   logic [15:0] ref_mem [0:DEPTH-1];
   int          write_cnt = 0;
   bit          both_seen = 1'b0;
   logic [71:0] outs;

   mem_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ready(ls_ready), .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_read_rq(mem_read_rq), .mem_write_rq(mem_write_rq), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr < 16'(DEPTH)) ? mem[mem_addr[6:0]] : 16'h0;
   assign outs = {if_ready, if_rsp_valid, if_rdata, ls_ready, ls_rsp_valid, ls_rdata, ls_err,
                  mem_read_rq, mem_write_rq, mem_addr, mem_wdata, busy};

   always @(posedge clk) begin
      if (mem_write_rq && mem_addr < 16'(DEPTH)) begin
         mem[mem_addr[6:0]] <= mem_wdata;
         write_cnt++;
      end
   end

   always @(negedge clk) if (mem_read_rq && mem_write_rq) both_seen = 1'b1;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_addr();
      if ($urandom_range(0, 9) < 8) return 16'($urandom_range(0, DEPTH - 1));
      return 16'($urandom_range(DEPTH, 65535));
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 72'h0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
      rst = 1'b1;
      step();
      checks++;
      if (outs !== 72'h0) begin errors++; $display("FAIL idle_outs got %h exp 0", outs); end
   endtask

   task automatic test_single_fetch();
      mem[5] = 16'h1234; ref_mem[5] = 16'h1234;
      if_req = 1'b1; if_addr = 16'd5;
      step();
      checks++;
      if ({if_ready, ls_ready, busy, mem_read_rq, mem_write_rq, mem_addr} !== {5'b10110, 16'd5}) begin
         errors++; $display("FAIL sf_access got rdy=%b lsr=%b busy=%b rq=%b%b addr=%h exp 1 0 1 10 0005",
                            if_ready, ls_ready, busy, mem_read_rq, mem_write_rq, mem_addr);
      end
      if_req = 1'b0;
      step();
      checks++;
      if ({if_rsp_valid, ls_rsp_valid, ls_err, busy, if_rdata} !== {4'b1001, 16'h1234}) begin
         errors++; $display("FAIL sf_resp got v=%b lv=%b err=%b busy=%b data=%h exp 1 0 0 1 1234",
                            if_rsp_valid, ls_rsp_valid, ls_err, busy, if_rdata);
      end
      step();
      checks++;
      if ({if_rsp_valid, busy, if_rdata} !== {2'b00, 16'h1234}) begin
         errors++; $display("FAIL sf_hold got v=%b busy=%b data=%h exp 0 0 1234", if_rsp_valid, busy, if_rdata);
      end
   endtask

   task automatic test_write_read();
      int wc0 = write_cnt;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'd127; ls_wdata = 16'hBEEF;
      step();
      checks++;
      if ({ls_ready, mem_write_rq, mem_read_rq, mem_addr, mem_wdata} !== {3'b110, 16'd127, 16'hBEEF}) begin
         errors++; $display("FAIL wr_access got rdy=%b w=%b r=%b addr=%h wd=%h exp 1 1 0 007f beef",
                            ls_ready, mem_write_rq, mem_read_rq, mem_addr, mem_wdata);
      end
      ls_req = 1'b0;
      ref_mem[127] = 16'hBEEF;
      step();
      checks++;
      if ({ls_rsp_valid, ls_err, ls_rdata} !== {2'b10, 16'h0}) begin
         errors++; $display("FAIL wr_resp got v=%b err=%b data=%h exp 1 0 0000", ls_rsp_valid, ls_err, ls_rdata);
      end
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'd127; ls_wdata = 16'h0;
      step();
      step();
      checks++;
      if ({ls_ready, mem_read_rq, mem_write_rq} !== 3'b110) begin
         errors++; $display("FAIL rd_access got rdy=%b r=%b w=%b exp 1 1 0", ls_ready, mem_read_rq, mem_write_rq);
      end
      ls_req = 1'b0;
      step();
      checks++;
      if ({ls_rsp_valid, ls_err, ls_rdata} !== {2'b10, 16'hBEEF}) begin
         errors++; $display("FAIL rd_resp got v=%b err=%b data=%h exp 1 0 beef", ls_rsp_valid, ls_err, ls_rdata);
      end
      checks++;
      if (write_cnt - wc0 != 1) begin errors++; $display("FAIL wr_count got %0d exp 1", write_cnt - wc0); end
      step();
   endtask

   task automatic test_out_of_range();
      int wc0 = write_cnt;
      mem[0] = 16'hA5A5; ref_mem[0] = 16'hA5A5;
      for (int k = 0; k < 2; k++) begin
         ls_req = 1'b1;
         ls_we = (k == 1);
         ls_addr = (k == 0) ? 16'd128 : 16'hFFFF;
         ls_wdata = 16'h7777;
         step();
         checks++;
         if ({ls_ready, mem_read_rq, mem_write_rq, mem_addr, mem_wdata} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL oor_access k=%0d got rdy=%b r=%b w=%b addr=%h wd=%h exp 1 0 0 0 0",
                               k, ls_ready, mem_read_rq, mem_write_rq, mem_addr, mem_wdata);
         end
         ls_req = 1'b0;
         step();
         checks++;
         if ({ls_rsp_valid, ls_err, ls_rdata} !== {2'b11, 16'h0}) begin
            errors++; $display("FAIL oor_resp k=%0d got v=%b err=%b data=%h exp 1 1 0000", k, ls_rsp_valid, ls_err, ls_rdata);
         end
         step();
      end
      checks++;
      if (mem[0] !== 16'hA5A5 || write_cnt != wc0) begin
         errors++; $display("FAIL oor_mem got mem0=%h writes=%0d exp a5a5 0", mem[0], write_cnt - wc0);
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] la = 16'($urandom_range(0, DEPTH - 1));
      if_req = 1'b1; if_addr = 16'd40;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = la;
      step();
      checks++;
      if ({ls_ready, if_ready} !== 2'b10) begin
         errors++; $display("FAIL sim_first got ls=%b if=%b exp 1 0", ls_ready, if_ready);
      end
      ls_req = 1'b0;
      step();
      checks++;
      if ({ls_rsp_valid, if_rsp_valid, ls_rdata} !== {2'b10, ref_mem[la[6:0]]}) begin
         errors++; $display("FAIL sim_ls_resp got v=%b iv=%b data=%h exp 1 0 %h", ls_rsp_valid, if_rsp_valid, ls_rdata, ref_mem[la[6:0]]);
      end
      step();
      step();
      checks++;
      if ({if_ready, ls_ready} !== 2'b10) begin
         errors++; $display("FAIL sim_second got if=%b ls=%b exp 1 0", if_ready, ls_ready);
      end
      if_req = 1'b0;
      step();
      checks++;
      if ({if_rsp_valid, if_rdata} !== {1'b1, ref_mem[40]}) begin
         errors++; $display("FAIL sim_if_resp got v=%b data=%h exp 1 %h", if_rsp_valid, if_rdata, ref_mem[40]);
      end
      step();
   endtask

   task automatic test_contention();
      bit          exp_f;
      bit          got_f;
      logic [15:0] exp_d;
      int          w;
      if_req = 1'b1; if_addr = 16'd10;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'($urandom_range(0, DEPTH - 1));
      // Starting from a cleared counter: four ls wins, then fetch, twice over.
      for (int g = 0; g < 10; g++) begin
         exp_f = (g == 4 || g == 9);
         w = 0;
         while (!(if_ready || ls_ready) && w < 4) begin step(); w++; end
         checks++;
         if (!(if_ready || ls_ready)) begin
            errors++; $display("FAIL cont_timeout g=%0d got no ready exp ready", g);
            break;
         end
         got_f = if_ready;
         exp_d = exp_f ? ref_mem[10] : ref_mem[ls_addr[6:0]];
         if (got_f !== exp_f) begin
            errors++; $display("FAIL cont_grant g=%0d got fetch=%b exp fetch=%b", g, got_f, exp_f);
         end
         if (got_f) if_req = 1'b0;
         step();
         checks++;
         if ((got_f ? if_rdata : ls_rdata) !== exp_d) begin
            errors++; $display("FAIL cont_data g=%0d got %h exp %h", g, got_f ? if_rdata : ls_rdata, exp_d);
         end
         if_req = 1'b1;
         if (!got_f) ls_addr = 16'($urandom_range(0, DEPTH - 1));
      end
      if_req = 1'b0; ls_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_access();
      mem[3] = 16'h1111; ref_mem[3] = 16'h1111;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'd3; ls_wdata = 16'h5555;
      step();
      checks++;
      if (mem_write_rq !== 1'b1) begin errors++; $display("FAIL rma_pre got w=%b exp 1", mem_write_rq); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (outs !== 72'h0) begin errors++; $display("FAIL rma_outs got %h exp 0", outs); end
      ls_req = 1'b0;
      step();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if ({if_rsp_valid, ls_rsp_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL rma_idle c=%0d got iv=%b lv=%b busy=%b exp 0 0 0", c, if_rsp_valid, ls_rsp_valid, busy);
         end
      end
      checks++;
      if (mem[3] !== 16'h1111) begin errors++; $display("FAIL rma_mem got %h exp 1111", mem[3]); end
   endtask

   task automatic test_random();
      bit          if_pend = 1'b0;
      bit          ls_pend = 1'b0;
      logic [15:0] ia = 16'h0;
      logic [15:0] la = 16'h0;
      logic [15:0] lw = 16'h0;
      bit          lwe = 1'b0;
      int          losses = 0;
      bit          fw;
      logic [15:0] a;
      bit          we;
      bit          inr;
      logic [15:0] exp_d;
      for (int n = 0; n < 150; n++) begin
         if (!if_pend && $urandom_range(0, 1) == 1) begin if_pend = 1'b1; ia = rand_addr(); end
         if (!ls_pend && ($urandom_range(0, 1) == 1 || !if_pend)) begin
            ls_pend = 1'b1; la = rand_addr(); lwe = 1'($urandom_range(0, 1)); lw = 16'($urandom);
         end
         if_req = if_pend; if_addr = ia;
         ls_req = ls_pend; ls_addr = la; ls_we = lwe; ls_wdata = lw;
         fw = if_pend && (!ls_pend || losses == STARVE_LIMIT);
         if (if_pend && ls_pend && !fw) losses = (losses < STARVE_LIMIT) ? losses + 1 : losses;
         else losses = 0;
         a = fw ? ia : la;
         we = fw ? 1'b0 : lwe;
         inr = (a < 16'(DEPTH));
         step();
         checks++;
         if ({if_ready, ls_ready} !== {fw, !fw}) begin
            errors++; $display("FAIL rnd_ready n=%0d got %b%b exp %b%b", n, if_ready, ls_ready, fw, !fw);
         end
         checks++;
         if ({mem_read_rq, mem_write_rq} !== {inr && !we, inr && we}) begin
            errors++; $display("FAIL rnd_rq n=%0d got %b%b exp %b%b", n, mem_read_rq, mem_write_rq, inr && !we, inr && we);
         end
         if (inr) begin
            checks++;
            if (mem_addr !== a || (we && mem_wdata !== lw)) begin
               errors++; $display("FAIL rnd_bus n=%0d got addr=%h wd=%h exp addr=%h wd=%h", n, mem_addr, mem_wdata, a, lw);
            end
         end
         if (fw) begin if_pend = 1'b0; if_req = 1'b0; end
         else begin ls_pend = 1'b0; ls_req = 1'b0; end
         step();
         exp_d = (inr && !we) ? ref_mem[a[6:0]] : 16'h0;
         if (inr && we) ref_mem[a[6:0]] = lw;
         checks++;
         if ({if_rsp_valid, ls_rsp_valid, ls_err} !== {fw, !fw, !inr}) begin
            errors++; $display("FAIL rnd_rsp n=%0d got %b%b%b exp %b%b%b", n, if_rsp_valid, ls_rsp_valid, ls_err, fw, !fw, !inr);
         end
         checks++;
         if ((fw ? if_rdata : ls_rdata) !== exp_d) begin
            errors++; $display("FAIL rnd_data n=%0d got %h exp %h", n, fw ? if_rdata : ls_rdata, exp_d);
         end
         step();
      end
      if_req = 1'b0; ls_req = 1'b0;
      step();
      checks++;
      if (both_seen !== 1'b0) begin errors++; $display("FAIL both_rq got 1 exp 0"); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      if_req = 1'b0; if_addr = 16'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 16'h0; ls_wdata = 16'h0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_single_fetch();
      test_write_read();
      test_out_of_range();
      test_simultaneous();
      test_contention();
      test_reset_mid_access();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
